// File: rtl/sfifo_1r1w_pkg.sv
// Shared definitions for the sfifo_1r1w FIFO: level width and flag threshold helpers.
package sfifo_1r1w_pkg;

    // Width of the level counter: must represent 0..2^aw inclusive.
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

    // almost_full threshold; a margin covering the whole FIFO pins the flag high.
    function automatic int af_threshold(input int depth, input int margin);
        return (margin >= depth) ? 0 : depth - margin;
    endfunction

    // almost_empty threshold; clamped so it never exceeds the full level.
    function automatic int ae_threshold(input int depth, input int margin);
        return (margin >= depth) ? depth : margin;
    endfunction

endpackage

// File: rtl/sfifo_1r1w_if.sv
// Valid/ready stream bundle. The source drives valid/data, the sink drives ready.
interface sfifo_1r1w_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    // Source side of the stream.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Sink side of the stream.
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/sfifo_1r1w_ram.sv
// DEPTH x DW simple dual-port storage. The read port is asynchronous; the
// controller captures rdata into its output register, so RAM data never
// reaches the FIFO output port combinationally. The array has no reset.
module sfifo_ram #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wadr] <= wdata;
        end
    end

    assign rdata = mem[radr];
endmodule

// File: rtl/sfifo_1r1w.sv
// Single-clock first-word-fall-through FIFO. The head word lives in an output
// register; the RAM holds the words behind it. level counts both, so the RAM
// never holds more than DEPTH-1 words and write/read pointers never collide
// while the RAM is non-empty.
module sfifo_1r1w
    import sfifo_1r1w_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 2,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    sfifo_1r1w_if.slave                in_if,
    sfifo_1r1w_if.master               out_if,
    output logic [level_width(AW)-1:0] level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       ovf_err
);
    localparam int             DEPTH   = 1 << AW;
    localparam int             LW      = level_width(AW);
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]  ONE_L   = LW'(1);
    localparam logic [LW-1:0]  AF_TH   = LW'(af_threshold(DEPTH, AF_MARGIN));
    localparam logic [LW-1:0]  AE_TH   = LW'(ae_threshold(DEPTH, AE_MARGIN));

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0] level_reg, level_next;
    logic [DW-1:0] head_reg, head_next;
    logic          ovf_reg, ovf_next;

    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;

    // Handshake decode: in_ready looks only at registered level and flush,
    // so out_ready has no combinational path to in_ready.
    assign in_ready  = (level_reg < DEPTH_L) & ~flush;
    assign out_valid = (level_reg != '0);
    assign push      = in_if.valid & in_ready;
    assign pop       = out_valid & out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = head_reg;

    assign level        = level_reg;
    assign almost_full  = (level_reg >= AF_TH);
    assign almost_empty = (level_reg <= AE_TH);
    assign ovf_err      = ovf_reg;

    sfifo_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .wen   (ram_wen),
        .wadr  (wr_ptr_reg),
        .wdata (in_if.data),
        .radr  (rd_ptr_reg),
        .rdata (ram_rdata)
    );

    // Next-state: pointer/level bookkeeping, head refill and overflow flag.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        head_next   = head_reg;
        ovf_next    = ovf_reg;
        ram_wen     = 1'b0;

        if (flush) begin
            // Flush wins over any pop; push is already blocked by in_ready.
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
            head_next   = '0;
            ovf_next    = 1'b0;
        end else begin
            if (push && pop) begin
                if (level_reg == ONE_L) begin
                    // RAM is empty: the incoming word becomes the head directly.
                    head_next = in_if.data;
                end else begin
                    head_next   = ram_rdata;
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                    ram_wen     = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                end
            end else if (push) begin
                if (level_reg == '0) begin
                    // Empty FIFO: bypass the RAM for one-cycle latency.
                    head_next = in_if.data;
                end else begin
                    ram_wen     = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                end
                level_next = level_reg + ONE_L;
            end else if (pop) begin
                if (level_reg > ONE_L) begin
                    // Refill the head from the oldest RAM word on the same edge.
                    head_next   = ram_rdata;
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end
                level_next = level_reg - ONE_L;
            end

            if (in_if.valid && !in_ready && (level_reg == DEPTH_L)) begin
                ovf_next = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            head_reg   <= head_next;
            ovf_reg    <= ovf_next;
        end
    end
endmodule

// File: tb/tb_sfifo_1r1w.sv
// Scoreboard bench for sfifo_1r1w (DW=32, AW=2, margins 1).
module tb_sfifo_1r1w;
    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [AW:0]  level;
    logic         almost_full;
    logic         almost_empty;
    logic         ovf_err;

    sfifo_1r1w_if #(.DW(DW)) in_if ();
    sfifo_1r1w_if #(.DW(DW)) out_if ();

    sfifo_1r1w #(
        .DW        (DW),
        .AW        (AW),
        .AF_MARGIN (1),
        .AE_MARGIN (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_if        (in_if),
        .out_if       (out_if),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    logic [31:0] exp_q[$];
    logic        ovf_m   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered outputs compared against the model after each edge.
    task automatic check_state();
        int m;
        m = exp_q.size();
        check("level", 32'(level), 32'(m));
        check("out_valid", 32'(out_if.valid), 32'(m != 0));
        check("almost_full", 32'(almost_full), 32'(m >= DEPTH - 1));
        check("almost_empty", 32'(almost_empty), 32'(m <= 1));
        check("ovf_err", 32'(ovf_err), 32'(ovf_m));
    endtask

    // One clock: evaluate handshakes at negedge, then clock and check.
    task automatic cycle();
        int  m;
        bit  push_e, pop_e;
        @(negedge clk);
        m      = exp_q.size();
        push_e = in_if.valid && (m < DEPTH) && !flush;
        pop_e  = (m != 0) && out_if.ready && !flush;
        check("in_ready", 32'(in_if.ready), 32'((m < DEPTH) && !flush));
        if (pop_e) begin
            check("pop_data", out_if.data, exp_q.pop_front());
            n_pops++;
        end
        if (push_e) exp_q.push_back(in_if.data);
        if (in_if.valid && (m == DEPTH) && !flush) ovf_m = 1'b1;
        if (flush) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        int p0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;

        // Reset values while rst_n is held low.
        #12;
        check("rst_in_ready", 32'(in_if.ready), 32'd1);
        check("rst_out_valid", 32'(out_if.valid), 32'd0);
        check("rst_out_data", out_if.data, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with the consumer stalled, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'(i * 32'h11);
            cycle();
        end
        in_if.valid = 1'b0;
        check("full_in_ready", 32'(in_if.ready), 32'd0);
        check("full_head", out_if.data, 32'h11);
        out_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        out_if.ready = 1'b0;

        // Streaming: one word per cycle at level 1.
        in_if.valid = 1'b1;
        in_if.data  = 32'h1000;
        cycle();
        out_if.ready = 1'b1;
        p0 = n_pops;
        for (int i = 1; i <= 100; i++) begin
            in_if.data = 32'h1000 + 32'(i);
            cycle();
        end
        check("stream_pops", 32'(n_pops - p0), 32'd100);
        in_if.valid = 1'b0;
        cycle();
        out_if.ready = 1'b0;

        // Simultaneous push/pop at level 1.
        in_if.valid = 1'b1;
        in_if.data  = 32'hA;
        cycle();
        in_if.data   = 32'hB;
        out_if.ready = 1'b1;
        cycle();
        check("pushpop_head", out_if.data, 32'hB);
        in_if.valid = 1'b0;
        cycle();
        out_if.ready = 1'b0;

        // Overflow at full, pop one, then flush with in_valid still high.
        for (int i = 0; i < 4; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'h200 + 32'(i);
            cycle();
        end
        in_if.data = 32'hDEAD;
        cycle();
        cycle();
        check("ovf_set", 32'(ovf_err), 32'd1);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        cycle();
        out_if.ready = 1'b0;
        check("ovf_head", out_if.data, 32'h201);
        in_if.valid = 1'b1;
        in_if.data  = 32'h204;
        cycle();
        flush        = 1'b1;
        out_if.ready = 1'b1;
        cycle();
        flush        = 1'b0;
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_ovf", 32'(ovf_err), 32'd0);

        // Asynchronous reset at level 3.
        for (int i = 0; i < 3; i++) begin
            in_if.valid = 1'b1;
            in_if.data  = 32'h300 + 32'(i);
            cycle();
        end
        in_if.valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        ovf_m = 1'b0;
        check("arst_level", 32'(level), 32'd0);
        check("arst_out_valid", 32'(out_if.valid), 32'd0);
        check("arst_out_data", out_if.data, 32'd0);
        check("arst_in_ready", 32'(in_if.ready), 32'd1);
        check("arst_ae", 32'(almost_empty), 32'd1);
        check("arst_af", 32'(almost_full), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_if.valid = 1'b1;
        in_if.data  = 32'h55;
        cycle();
        in_if.valid = 1'b0;
        check("post_rst_valid", 32'(out_if.valid), 32'd1);
        check("post_rst_head", out_if.data, 32'h55);
        out_if.ready = 1'b1;
        cycle();
        out_if.ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
